pll_lock_supervisor: RTL and testbench

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

---
 rtl/pll_sup_pkg.sv | 27 ++
 rtl/pll_lock_sync.sv | 31 +++
 rtl/pll_lock_supervisor.sv | 189 ++++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pll_sup_pkg.sv
// ============================================================================
// pll_sup_pkg : shared state encoding and counter widths for the PLL lock supervisor
// Rev 1.0
// ============================================================================
`default_nettype none

package pll_sup_pkg;

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } sup_state_e;

    localparam int RETRY_W = 4;
    localparam int STAT_W  = 8;

    // Width needed to count 0 .. n-1 (never below one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pll_lock_sync.sv
// ============================================================================
// pll_lock_sync : two-flop synchronizer bringing the PLL lock flag into refclk
// Rev 1.0
// ============================================================================
`default_nettype none

module pll_lock_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/pll_lock_supervisor.sv
// ============================================================================
// pll_lock_supervisor : PLL reset / lock-qualification sequencer with retry limit.
// Optional lock-loss statistics output enabled by PLL_LOCK_SUPERVISOR_STATS_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 256,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES         = 3
) (
    input  logic               refclk,
    input  logic               rst_n,
    input  logic               locked,
    input  logic               relock_req,
    output logic               pll_rst,
    output logic               sys_rst,
    output logic               ready,
    output logic               fail,
    output logic [RETRY_W-1:0] retry_cnt
`ifdef PLL_LOCK_SUPERVISOR_STATS_EN
    ,
    output logic [STAT_W-1:0]  lost_cnt
`endif
);

    localparam int RST_W = cnt_width(PLL_RST_CYCLES);
    localparam int STB_W = cnt_width(LOCK_STABLE_CYCLES);
    localparam int TMO_W = cnt_width(LOCK_TIMEOUT_CYCLES);

    localparam logic [RST_W-1:0]   RST_LAST  = RST_W'(PLL_RST_CYCLES - 1);
    localparam logic [STB_W-1:0]   STB_LAST  = STB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

    sup_state_e         state_q,     state_d;
    logic [RST_W-1:0]   rst_cnt_q,   rst_cnt_d;
    logic [STB_W-1:0]   stb_cnt_q,   stb_cnt_d;
    logic [TMO_W-1:0]   tmo_cnt_q,   tmo_cnt_d;
    logic [RETRY_W-1:0] retry_cnt_q, retry_cnt_d;
    logic               pll_rst_q,   pll_rst_d;
    logic               sys_rst_q,   sys_rst_d;
    logic               ready_q,     ready_d;
    logic               fail_q,      fail_d;

    logic               lock_s;
    logic               tmo_hit;
    logic               stb_done;
    logic [RETRY_W-1:0] retry_inc;

    pll_lock_sync u_sync (
        .clk_i  (refclk),
        .rst_ni (rst_n),
        .d_i    (locked),
        .q_o    (lock_s)
    );

    assign tmo_hit   = (tmo_cnt_q == TMO_LAST);
    assign stb_done  = (state_q == ST_STABLE) && lock_s && (stb_cnt_q == STB_LAST);
    assign retry_inc = retry_cnt_q + RETRY_W'(1);

`ifdef PLL_LOCK_SUPERVISOR_STATS_EN
    logic               lost_evt;
    logic [STAT_W-1:0]  lost_cnt_q;
`endif

    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        stb_cnt_d   = stb_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        retry_cnt_d = retry_cnt_q;
`ifdef PLL_LOCK_SUPERVISOR_STATS_EN
        lost_evt    = 1'b0;
`endif
        if (relock_req) begin
            state_d     = ST_RESET_PLL;
            rst_cnt_d   = '0;
            stb_cnt_d   = '0;
            tmo_cnt_d   = '0;
            retry_cnt_d = '0;
        end else begin
            case (state_q)
                ST_RESET_PLL: begin
                    if (rst_cnt_q == RST_LAST) begin
                        state_d   = ST_WAIT_LOCK;
                        rst_cnt_d = '0;
                        tmo_cnt_d = '0;
                    end else begin
                        rst_cnt_d = rst_cnt_q + RST_W'(1);
                    end
                end
                ST_WAIT_LOCK, ST_STABLE: begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                    // A qualified lock in the timeout cycle still counts as success.
                    if (stb_done) begin
                        state_d     = ST_RUN;
                        retry_cnt_d = '0;
                    end else if (tmo_hit) begin
                        retry_cnt_d = retry_inc;
                        state_d     = (retry_inc == RETRY_MAX) ? ST_FAIL : ST_RESET_PLL;
                        rst_cnt_d   = '0;
                        stb_cnt_d   = '0;
                        tmo_cnt_d   = '0;
                    end else if (state_q == ST_WAIT_LOCK) begin
                        if (lock_s) begin
                            state_d   = ST_STABLE;
                            stb_cnt_d = '0;
                        end
                    end else if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                    end else begin
                        stb_cnt_d = stb_cnt_q + STB_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_d   = ST_RESET_PLL;
                        rst_cnt_d = '0;
`ifdef PLL_LOCK_SUPERVISOR_STATS_EN
                        lost_evt  = 1'b1;
`endif
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_RESET_PLL;
                end
            endcase
        end

        // Outputs are decoded from the next state so they register with it.
        pll_rst_d = (state_d == ST_RESET_PLL) || (state_d == ST_FAIL);
        sys_rst_d = (state_d != ST_RUN);
        ready_d   = (state_d == ST_RUN);
        fail_d    = (state_d == ST_FAIL);
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RESET_PLL;
            rst_cnt_q   <= '0;
            stb_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            retry_cnt_q <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            stb_cnt_q   <= stb_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            retry_cnt_q <= retry_cnt_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_q   <= sys_rst_d;
            ready_q     <= ready_d;
            fail_q      <= fail_d;
        end
    end

`ifdef PLL_LOCK_SUPERVISOR_STATS_EN
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lost_cnt_q <= '0;
        end else if (lost_evt && (lost_cnt_q != {STAT_W{1'b1}})) begin
            lost_cnt_q <= lost_cnt_q + STAT_W'(1);
        end
    end

    assign lost_cnt = lost_cnt_q;
`endif

    assign pll_rst   = pll_rst_q;
    assign sys_rst   = sys_rst_q;
    assign ready     = ready_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
// ============================================================================
// tb_pll_lock_supervisor : scoreboard bench for pll_lock_supervisor
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pll_lock_supervisor;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b1;
    logic       locked     = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fail;
    logic [3:0] retry_cnt;
`ifdef PLL_LOCK_SUPERVISOR_STATS_EN
    logic [7:0] lost_cnt;
`endif

    pll_lock_supervisor #(
        .PLL_RST_CYCLES      (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (32),
        .MAX_RETRIES         (3)
    ) dut (
        .refclk     (clk),
        .rst_n      (rst_n),
        .locked     (locked),
        .relock_req (relock_req),
        .pll_rst    (pll_rst),
        .sys_rst    (sys_rst),
        .ready      (ready),
        .fail       (fail),
        .retry_cnt  (retry_cnt)
`ifdef PLL_LOCK_SUPERVISOR_STATS_EN
        ,
        .lost_cnt   (lost_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Output vector {pll_rst, sys_rst, ready, fail, retry_cnt[3:0]}; gap is the
    // number of cycles since the previous change or the last cycle in reset (-1 = unchecked).
    typedef struct {
        string      name;
        logic [7:0] vec;
        int         gap;
    } exp_t;

    typedef struct {
        string name;
        int    act;
        int    want;
    } dir_t;

    exp_t       exp_q[$];
    dir_t       dir_q[$];
    int         n_cmp    = 0;
    int         n_bad    = 0;
    int         cyc      = 0;
    int         last_cyc = 0;
    logic       mon_en   = 1'b0;
    logic [7:0] prev     = 8'hxx;

    task automatic expect_out(input string name, input logic [7:0] vec, input int gap);
        exp_t e;
        e.name = name;
        e.vec  = vec;
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int want);
        dir_t d;
        d.name = name;
        d.act  = act;
        d.want = want;
        dir_q.push_back(d);
    endtask

    always @(negedge clk) begin : monitor
        logic [7:0] cur;
        exp_t       e;
        dir_t       d;
        cyc = cyc + 1;
        if (mon_en) begin
            cur = {pll_rst, sys_rst, ready, fail, retry_cnt};
            if (cur !== prev) begin
                if (exp_q.size() == 0) begin
                    n_cmp = n_cmp + 1;
                    n_bad = n_bad + 1;
                    $display("FAIL unexpected_change: outputs %b at cycle %0d, no change was due", cur, cyc);
                end else begin
                    e = exp_q.pop_front();
                    n_cmp = n_cmp + 1;
                    if (cur !== e.vec) begin
                        n_bad = n_bad + 1;
                        $display("FAIL %s: outputs %b, want %b", e.name, cur, e.vec);
                    end
                    if (e.gap >= 0) begin
                        n_cmp = n_cmp + 1;
                        if ((cyc - last_cyc) != e.gap) begin
                            n_bad = n_bad + 1;
                            $display("FAIL %s_timing: after %0d cycles, want %0d", e.name, cyc - last_cyc, e.gap);
                        end
                    end
                end
                prev     = cur;
                last_cyc = cyc;
            end
            if (!rst_n) last_cyc = cyc;
        end
        while (dir_q.size() > 0) begin
            d = dir_q.pop_front();
            n_cmp = n_cmp + 1;
            if (d.act != d.want) begin
                n_bad = n_bad + 1;
                $display("FAIL %s: got %0d, want %0d", d.name, d.act, d.want);
            end
        end
    end

    task automatic assert_rst();
        @(negedge clk);
        #2 rst_n = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic release_rst(input int hold);
        repeat (hold) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic expect_fail_sequence(input string tag);
        expect_out({tag, "_reset"}, 8'hC0, -1);
        expect_out({tag, "_wait0"}, 8'h40, 4);
        expect_out({tag, "_retry1"}, 8'hC1, 32);
        expect_out({tag, "_wait1"}, 8'h41, 4);
        expect_out({tag, "_retry2"}, 8'hC2, 32);
        expect_out({tag, "_wait2"}, 8'h42, 4);
        expect_out({tag, "_fail"}, 8'hD3, 32);
    endtask

    initial begin
        // Lock present from the start: reset period, qualification, then a 1-cycle lock drop.
        expect_out("s1_reset", 8'hC0, -1);
        expect_out("s1_wait", 8'h40, 4);
        expect_out("s1_run", 8'h20, 9);
        expect_out("s1_loss", 8'hC0, 10);
        expect_out("s1_rewait", 8'h40, 4);
        expect_out("s1_rerun", 8'h20, 9);
        locked = 1'b1;
        assert_rst();
        release_rst(3);
        repeat (20) @(posedge clk);
        #2 locked = 1'b0;
        @(posedge clk);
        #2 locked = 1'b1;
        repeat (20) @(posedge clk);
        check("s1_drain", exp_q.size(), 0);
`ifdef PLL_LOCK_SUPERVISOR_STATS_EN
        check("s1_lost_cnt", int'(lost_cnt), 1);
`endif

        // No lock: three timed-out attempts, FAIL held, then relock_req recovers.
        expect_fail_sequence("s2");
        expect_out("s2_relock", 8'hC0, 53);
        expect_out("s2_wait", 8'h40, 4);
        expect_out("s2_run", 8'h20, 9);
        assert_rst();
        locked = 1'b0;
        release_rst(3);
        repeat (150) @(posedge clk);
        #2 locked = 1'b1;
        repeat (10) @(posedge clk);
        #2 relock_req = 1'b1;
        @(posedge clk);
        #2 relock_req = 1'b0;
        repeat (20) @(posedge clk);
        check("s2_drain", exp_q.size(), 0);

        // Lock toggling every 5 cycles never qualifies; timeouts still land on cycle 32.
        expect_fail_sequence("s3");
        assert_rst();
        locked = 1'b0;
        release_rst(3);
        for (int k = 1; k <= 140; k++) begin
            @(posedge clk);
            if ((k % 5) == 0) #2 locked = ~locked;
        end
        check("s3_drain", exp_q.size(), 0);

        // Reset pulse while in STABLE forces reset outputs immediately, then a full restart.
        expect_out("s4_reset", 8'hC0, -1);
        expect_out("s4_wait", 8'h40, 4);
        expect_out("s4_pulse", 8'hC0, -1);
        expect_out("s4_rewait", 8'h40, 4);
        expect_out("s4_run", 8'h20, 9);
        assert_rst();
        locked = 1'b1;
        release_rst(3);
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("s4_async_pll_rst", int'(pll_rst), 1);
        check("s4_async_sys_rst", int'(sys_rst), 1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        check("s4_drain", exp_q.size(), 0);
        check("s4_retry_cnt", int'(retry_cnt), 0);
`ifdef PLL_LOCK_SUPERVISOR_STATS_EN
        check("s4_lost_cnt", int'(lost_cnt), 0);
`endif
        repeat (3) @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
